seq_mag_comparator: RTL
=======================

SEQ_MAG_COMPARATOR -- requirements
Module: seq_mag_comparator

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 32: operand width in bits, legal range 4..256.
REQ-002 The block SHALL provide parameter CHUNK, default 4: bits compared per cycle; WIDTH mod CHUNK != 0 SHALL be an elaboration error.
REQ-003 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  is the reset, asynchronous and active-low.
REQ-005 Port in_valid  input  1  means the operand pair is offered.
REQ-006 Port in_ready  output  1  means the block accepts an operand pair.
REQ-007 Port a  input  WIDTH  is operand A.
REQ-008 Port b  input  WIDTH  is operand B.
REQ-009 Port signed_mode  input  1  selects two's-complement comparison when high; it exists only under CMP_SIGNED_EN.
REQ-010 Port out_valid  output  1  means a result is presented.
REQ-011 Port out_ready  input  1  means the consumer takes the result.
REQ-012 Ports less, equal, greater  output  1 each  are the result flags for A<B, A==B and A>B.

Function
REQ-013 FSM states SHALL be IDLE, COMPARE and DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-014 At IDLE with in_valid&&in_ready at an edge, a, b and signed_mode SHALL be latched, the chunk index set to NCHUNK-1 (NCHUNK=WIDTH/CHUNK), and the state SHALL become COMPARE.
REQ-015 At each COMPARE edge, one CHUNK slice per operand SHALL be compared, MSB slice first, and the index SHALL decrement.
REQ-016 Early out: if the slices differ, the edge SHALL register greater or less from that slice and the state SHALL become DONE.
REQ-017 If index==0 and the slices are equal, the edge SHALL register equal=1 and the state SHALL become DONE.
REQ-018 Latency from the acceptance edge to out_valid SHALL be k edges, where k is the 1-based position, counted from the MSB, of the first differing slice, or NCHUNK for equal operands.
REQ-019 In DONE, exactly one flag SHALL be 1; flags and out_valid SHALL hold stable until out_valid&&out_ready at an edge, which SHALL return the state to IDLE.
REQ-020 Flags SHALL retain the last result after the handshake; they are meaningful only while out_valid=1.
REQ-021 Operand inputs SHALL be ignored outside the IDLE acceptance edge; changes during COMPARE or DONE SHALL NOT affect the result.
REQ-022 A new operand pair SHALL NOT be accepted in the same edge as the result handshake; the earliest next acceptance is the following edge.
REQ-023 Unsigned comparison SHALL treat operands as 0..2^WIDTH-1, so all-ones > 0.

Reset
REQ-024 While rst_n=0: state=IDLE, in_ready=1, out_valid=0, less=equal=greater=0, index=NCHUNK-1, latched operands=0.
REQ-025 Reset asserted during COMPARE or DONE SHALL abort the operation with no result delivered; the block SHALL accept again on the first edge after release.

Configuration
REQ-026 With macro CMP_SIGNED_EN defined, signed_mode exists; when latched high, the MSB of the top slice of both operands SHALL be inverted before comparison, giving two's-complement order.
REQ-027 Without CMP_SIGNED_EN, signed_mode is absent and all comparisons SHALL be unsigned.

Structure
REQ-028 Shared package cmp_pkg SHALL hold the FSM state enum (IDLE/COMPARE/DONE) and the default constants CMP_WIDTH_DEF=32 and CMP_CHUNK_DEF=4.
REQ-029 One combinational sub-module, chunk_cmp, parametrised by CHUNK, SHALL produce the slice gt/eq/lt; the FSM, index counter and operand registers SHALL live in seq_mag_comparator.

Verification
REQ-030 WIDTH=32, CHUNK=4, a=b=0x1234_5678 -> out_valid 8 edges after acceptance, equal=1.
REQ-031 a=0x9000_0000, b=0x1FFF_FFFF, unsigned -> out_valid 1 edge after acceptance, greater=1; the same operands with signed_mode=1 (CMP_SIGNED_EN) -> less=1.
REQ-032 a=0x0000_0005, b=0x0000_0007 -> less=1 after 8 edges; out_ready held 0 for 5 cycles -> flags and out_valid stable, in_ready=0.
REQ-033 Operands changed every cycle during COMPARE -> result matches the pair latched at acceptance; back-to-back requests -> a one-edge gap after each result handshake.
REQ-034 rst_n pulsed low at the 3rd COMPARE edge -> all outputs 0 and in_ready=1 immediately; the next pair completes normally.
REQ-035 Random sweep with WIDTH=8, CHUNK=2 over all 65536 pairs -> flags match a reference model, and latency matches REQ-018.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared types and defaults for the sequential magnitude comparator.
package cmp_pkg;

    localparam int unsigned CMP_WIDTH_DEF = 32;
    localparam int unsigned CMP_CHUNK_DEF = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } cmp_state_e;

    typedef struct packed {
        logic less;
        logic equal;
        logic greater;
    } cmp_flags_t;

endpackage

// File: rtl/chunk_cmp.sv
// Combinational unsigned compare of one CHUNK-wide slice pair.
module chunk_cmp
    import cmp_pkg::*;
#(
    parameter int unsigned CHUNK = CMP_CHUNK_DEF
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             gt_c,
    output logic             eq_c,
    output logic             lt_c
);

    assign gt_c = (a > b);
    assign eq_c = (a == b);
    assign lt_c = (a < b);

endmodule

// File: rtl/seq_mag_comparator.sv
// Sequential magnitude comparator: walks operand slices MSB-first, CHUNK bits per cycle.
// Optional two's-complement ordering via `define CMP_SIGNED_EN (adds signed_mode port).
module seq_mag_comparator
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = CMP_WIDTH_DEF,
    parameter int unsigned CHUNK = CMP_CHUNK_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef CMP_SIGNED_EN
    input  logic             signed_mode,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic             less,
    output logic             equal,
    output logic             greater
);

    if (WIDTH < 4 || WIDTH > 256) begin : g_bad_width
        $error("seq_mag_comparator: WIDTH must be in 4..256");
    end
    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("seq_mag_comparator: WIDTH must be a multiple of CHUNK");
    end

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned OFF_W  = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);

    cmp_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    cmp_flags_t       flags_q, flags_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
`ifdef CMP_SIGNED_EN
    logic             smode_q, smode_d;
`endif

    logic [OFF_W-1:0] off;
    logic [CHUNK-1:0] a_sl, b_sl;
    logic             gt_c, eq_c, lt_c;

    // Current slice; in signed mode the sign bit of the top slice is flipped on both sides.
    always_comb begin
        off  = OFF_W'(32'(idx_q) * CHUNK);
        a_sl = a_q[off +: CHUNK];
        b_sl = b_q[off +: CHUNK];
`ifdef CMP_SIGNED_EN
        if (smode_q && (idx_q == IDX_LAST)) begin
            a_sl[CHUNK-1] = ~a_sl[CHUNK-1];
            b_sl[CHUNK-1] = ~b_sl[CHUNK-1];
        end
`endif
    end

    chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
        .a    (a_sl),
        .b    (b_sl),
        .gt_c (gt_c),
        .eq_c (eq_c),
        .lt_c (lt_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= IDX_LAST;
            a_q         <= '0;
            b_q         <= '0;
            flags_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef CMP_SIGNED_EN
            smode_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            flags_q     <= flags_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef CMP_SIGNED_EN
            smode_q     <= smode_d;
`endif
        end
    end

    // Next-state and registered-output logic; first differing slice ends the walk early.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        flags_d     = flags_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
`ifdef CMP_SIGNED_EN
        smode_d     = smode_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d        = a;
                    b_d        = b;
                    idx_d      = IDX_LAST;
                    state_d    = COMPARE;
                    in_ready_d = 1'b0;
`ifdef CMP_SIGNED_EN
                    smode_d    = signed_mode;
`endif
                end
            end
            COMPARE: begin
                if (idx_q != '0) begin
                    idx_d = idx_q - IDX_W'(1);
                end
                if (!eq_c) begin
                    flags_d     = '{less: lt_c, equal: 1'b0, greater: gt_c};
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end else if (idx_q == '0) begin
                    flags_d     = '{less: 1'b0, equal: 1'b1, greater: 1'b0};
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign less      = flags_q.less;
    assign equal     = flags_q.equal;
    assign greater   = flags_q.greater;

endmodule
